// File: rtl/dfp_arbiter_pkg.sv
// Shared cache-side types for the DFP arbiter: grant states, requester sides
// and the default cacheline width.
package dfp_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D
  } arb_state_t;

  typedef enum logic {
    SIDE_I,
    SIDE_D
  } arb_side_t;

  localparam int LINE_W = 256;

endpackage

// File: rtl/dfp_arbiter.sv
// Two-requester DFP arbiter: the I-cache and D-cache share one memory port,
// one outstanding transaction at a time, granted until memory responds.
module dfp_arbiter #(
  parameter bit RR_EN  = 1'b1,
  parameter int LINE_W = dfp_arbiter_pkg::LINE_W
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [31:0]       i_dfp_addr,
  input  logic              i_dfp_read,
  input  logic              i_dfp_write,
  input  logic [LINE_W-1:0] i_dfp_wdata,
  output logic [LINE_W-1:0] i_dfp_rdata,
  output logic              i_dfp_resp,

  input  logic [31:0]       d_dfp_addr,
  input  logic              d_dfp_read,
  input  logic              d_dfp_write,
  input  logic [LINE_W-1:0] d_dfp_wdata,
  output logic [LINE_W-1:0] d_dfp_rdata,
  output logic              d_dfp_resp,

  output logic [31:0]       mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  import dfp_arbiter_pkg::*;

  arb_state_t state_q, state_d;
  arb_side_t  last_grant_q, last_grant_d;
  logic       i_pend, d_pend;
  logic       own_i, own_d;

  // Tie-break between two simultaneous requests seen in IDLE.
  function automatic arb_side_t pick_tie(input arb_side_t last);
    if (RR_EN) return (last == SIDE_I) ? SIDE_D : SIDE_I;
    return SIDE_D;
  endfunction

  assign i_pend = i_dfp_read | i_dfp_write;
  assign d_pend = d_dfp_read | d_dfp_write;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (i_pend && d_pend)
          state_d = (pick_tie(last_grant_q) == SIDE_D) ? GRANT_D : GRANT_I;
        else if (i_pend)
          state_d = GRANT_I;
        else if (d_pend)
          state_d = GRANT_D;
      end
      GRANT_I: if (mem_resp) state_d = d_pend ? GRANT_D : IDLE;
      GRANT_D: if (mem_resp) state_d = i_pend ? GRANT_I : IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      if (state_d == GRANT_I) last_grant_d = SIDE_I;
      if (state_d == GRANT_D) last_grant_d = SIDE_D;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= SIDE_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Ownership is masked by rst so the memory port and both resps go quiet
  // the moment reset is asserted, even before the state register clears.
  assign own_i = (state_q == GRANT_I) && !rst;
  assign own_d = (state_q == GRANT_D) && !rst;

  assign mem_addr  = own_i ? i_dfp_addr  : (own_d ? d_dfp_addr  : '0);
  assign mem_read  = own_i ? i_dfp_read  : (own_d ? d_dfp_read  : 1'b0);
  assign mem_write = own_i ? i_dfp_write : (own_d ? d_dfp_write : 1'b0);
  assign mem_wdata = own_i ? i_dfp_wdata : (own_d ? d_dfp_wdata : '0);

  assign i_dfp_rdata = mem_rdata;
  assign d_dfp_rdata = mem_rdata;
  assign i_dfp_resp  = own_i && mem_resp;
  assign d_dfp_resp  = own_d && mem_resp;

endmodule

// File: tb/tb_dfp_arbiter.sv
// Bench for dfp_arbiter: instance 0 is round-robin, instance 1 fixed D priority;
// directed scenarios plus a random run against a transaction-level owner model.
module tb_dfp_arbiter;

  localparam int LW   = 256;
  localparam int NONE = 0;
  localparam int SI   = 1;
  localparam int SD   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [31:0]   i_addr[2], d_addr[2], mem_addr[2];
  logic          i_read[2], i_write[2], d_read[2], d_write[2];
  logic [LW-1:0] i_wdata[2], d_wdata[2], i_rdata[2], d_rdata[2], mem_wdata[2];
  logic          i_resp[2], d_resp[2], mem_read[2], mem_write[2];
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;

  int total, bad;
  int m_owner[2], m_last[2], m_next[2], m_lnext[2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    dfp_arbiter #(.RR_EN(k == 0), .LINE_W(LW)) u_dut (
      .clk(clk), .rst(rst),
      .i_dfp_addr(i_addr[k]), .i_dfp_read(i_read[k]), .i_dfp_write(i_write[k]),
      .i_dfp_wdata(i_wdata[k]), .i_dfp_rdata(i_rdata[k]), .i_dfp_resp(i_resp[k]),
      .d_dfp_addr(d_addr[k]), .d_dfp_read(d_read[k]), .d_dfp_write(d_write[k]),
      .d_dfp_wdata(d_wdata[k]), .d_dfp_rdata(d_rdata[k]), .d_dfp_resp(d_resp[k]),
      .mem_addr(mem_addr[k]), .mem_read(mem_read[k]), .mem_write(mem_write[k]),
      .mem_wdata(mem_wdata[k]), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );
  end

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic bit pending(int k, int side);
    if (side == SI) return i_read[k] | i_write[k];
    return d_read[k] | d_write[k];
  endfunction

  // Memory-port bundle the owner model predicts for instance k.
  function automatic logic [LW+33:0] exp_mem(int k);
    if (m_owner[k] == SI) return {i_read[k], i_write[k], i_addr[k], i_wdata[k]};
    if (m_owner[k] == SD) return {d_read[k], d_write[k], d_addr[k], d_wdata[k]};
    return '0;
  endfunction

  // Advance one clock: the owner model decides who holds the port next cycle
  // from the inputs settled just before the edge.
  task automatic tick();
    for (int k = 0; k < 2; k++) begin
      int n, l, other;
      n = m_owner[k];
      l = m_last[k];
      if (rst) begin
        n = NONE;
        l = SI;
      end else if (m_owner[k] == NONE) begin
        if (pending(k, SI) && pending(k, SD)) n = (k == 0 && m_last[k] == SD) ? SI : SD;
        else if (pending(k, SI)) n = SI;
        else if (pending(k, SD)) n = SD;
      end else if (mem_resp) begin
        other = (m_owner[k] == SI) ? SD : SI;
        n = pending(k, other) ? other : NONE;
      end
      if (!rst && n != NONE && n != m_owner[k]) l = n;
      m_next[k]  = n;
      m_lnext[k] = l;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = m_next[k];
      m_last[k]  = m_lnext[k];
    end
    #1;
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      i_addr[k] = '0; i_read[k] = 1'b0; i_write[k] = 1'b0; i_wdata[k] = '0;
      d_addr[k] = '0; d_read[k] = 1'b0; d_write[k] = 1'b0; d_wdata[k] = '0;
    end
    mem_resp = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [LW-1:0] pat;
    rst = 1'b1;
    clear_inputs();
    pat = rand_line();
    mem_rdata = pat;
    for (int k = 0; k < 2; k++) begin
      i_read[k] = 1'b1; i_addr[k] = 32'h1234; d_write[k] = 1'b1; d_addr[k] = 32'h5678;
    end
    mem_resp = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({mem_read[k], mem_write[k], mem_addr[k], mem_wdata[k], i_resp[k], d_resp[k]} !== '0) begin
        bad++;
        $display("FAIL reset_outputs k=%0d got rd=%b wr=%b addr=%h iresp=%b dresp=%b exp all zero",
                 k, mem_read[k], mem_write[k], mem_addr[k], i_resp[k], d_resp[k]);
      end
      total++;
      if ({i_rdata[k], d_rdata[k]} !== {pat, pat}) begin
        bad++;
        $display("FAIL rdata_passthru k=%0d got i=%h d=%h exp=%h", k, i_rdata[k], d_rdata[k], pat);
      end
    end
    rst = 1'b0;
    clear_inputs();
    tick();
  endtask

  task automatic test_single_read();
    logic [LW-1:0] pat;
    for (int k = 0; k < 2; k++) begin
      i_read[k] = 1'b1; i_addr[k] = 32'h0000_1000;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (mem_read[k] !== 1'b0) begin
        bad++; $display("FAIL single_latency0 k=%0d got mem_read=%b exp 0", k, mem_read[k]);
      end
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({mem_read[k], mem_write[k], mem_addr[k], i_resp[k], d_resp[k]} !== {2'b10, 32'h0000_1000, 2'b00}) begin
          bad++;
          $display("FAIL single_grant c=%0d k=%0d got rd=%b wr=%b addr=%h ir=%b dr=%b exp rd=1 addr=00001000",
                   c, k, mem_read[k], mem_write[k], mem_addr[k], i_resp[k], d_resp[k]);
        end
      end
    end
    tick();
    pat = rand_line();
    mem_rdata = pat;
    mem_resp = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({i_resp[k], d_resp[k], i_rdata[k]} !== {2'b10, pat}) begin
        bad++;
        $display("FAIL single_resp k=%0d got ir=%b dr=%b rdata=%h exp ir=1 dr=0 rdata=%h",
                 k, i_resp[k], d_resp[k], i_rdata[k], pat);
      end
    end
    tick();
    clear_inputs();
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (mem_read[k] !== 1'b0) begin
        bad++; $display("FAIL single_release k=%0d got mem_read=%b exp 0", k, mem_read[k]);
      end
    end
  endtask

  task automatic test_tie();
    logic [LW+33:0] exp_b;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      i_read[k] = 1'b1; i_addr[k] = 32'h100;
      d_write[k] = 1'b1; d_addr[k] = 32'h200; d_wdata[k] = {32{8'hA5}};
    end
    tick();
    exp_b = {1'b0, 1'b1, 32'h200, {32{8'hA5}}};
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({mem_read[k], mem_write[k], mem_addr[k], mem_wdata[k]} !== exp_b) begin
        bad++;
        $display("FAIL tie_first_d k=%0d got rd=%b wr=%b addr=%h wdata=%h exp wr=1 addr=200 wdata=a5..",
                 k, mem_read[k], mem_write[k], mem_addr[k], mem_wdata[k]);
      end
    end
    mem_resp = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({i_resp[k], d_resp[k]} !== 2'b01) begin
        bad++; $display("FAIL tie_d_resp k=%0d got ir=%b dr=%b exp ir=0 dr=1", k, i_resp[k], d_resp[k]);
      end
    end
    tick();
    for (int k = 0; k < 2; k++) d_write[k] = 1'b0;
    mem_resp = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({mem_read[k], mem_write[k], mem_addr[k]} !== {2'b10, 32'h100}) begin
        bad++;
        $display("FAIL tie_handoff_i k=%0d got rd=%b wr=%b addr=%h exp rd=1 wr=0 addr=100",
                 k, mem_read[k], mem_write[k], mem_addr[k]);
      end
    end
    mem_resp = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic test_contention();
    int exp_seq[6] = '{SD, SI, SD, SI, SD, SI};
    int obs;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      i_read[k] = 1'b1; i_addr[k] = 32'h100; d_read[k] = 1'b1; d_addr[k] = 32'h200;
    end
    mem_resp = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        obs = d_resp[k] ? SD : (i_resp[k] ? SI : NONE);
        total++;
        if (obs !== exp_seq[n]) begin
          bad++; $display("FAIL contention n=%0d k=%0d got side=%0d exp side=%0d", n, k, obs, exp_seq[n]);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      i_read[k] = 1'b0; d_read[k] = 1'b0;
    end
    tick();
    clear_inputs();
  endtask

  // A single-side grant precedes each IDLE tie so round-robin and fixed
  // priority disagree on every other round.
  task automatic test_idle_ties();
    int pre, exp_side, obs;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      pre = (r % 2 == 0) ? SI : SD;
      for (int k = 0; k < 2; k++) begin
        i_addr[k] = 32'h100; d_addr[k] = 32'h200;
        if (pre == SI) i_read[k] = 1'b1; else d_read[k] = 1'b1;
      end
      tick();
      mem_resp = 1'b1;
      tick();
      clear_inputs();
      for (int k = 0; k < 2; k++) begin
        i_read[k] = 1'b1; i_addr[k] = 32'h100; d_read[k] = 1'b1; d_addr[k] = 32'h200;
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        exp_side = (k == 0 && pre == SD) ? SI : SD;
        obs = (mem_addr[k] == 32'h200) ? SD : ((mem_addr[k] == 32'h100) ? SI : NONE);
        total++;
        if (obs !== exp_side) begin
          bad++; $display("FAIL idle_tie r=%0d k=%0d got side=%0d exp side=%0d", r, k, obs, exp_side);
        end
      end
      clear_inputs();
      mem_resp = 1'b1;
      tick();
      mem_resp = 1'b0;
    end
  endtask

  task automatic test_stray();
    do_reset();
    mem_resp = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({i_resp[k], d_resp[k], mem_read[k], mem_write[k]} !== 4'b0000) begin
          bad++;
          $display("FAIL stray c=%0d k=%0d got ir=%b dr=%b rd=%b wr=%b exp all 0",
                   c, k, i_resp[k], d_resp[k], mem_read[k], mem_write[k]);
        end
      end
      tick();
    end
    mem_resp = 1'b0;
    for (int k = 0; k < 2; k++) begin
      d_write[k] = 1'b1; d_addr[k] = 32'h300;
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({mem_read[k], mem_write[k], mem_addr[k]} !== {2'b01, 32'h300}) begin
        bad++;
        $display("FAIL stray_then_grant k=%0d got rd=%b wr=%b addr=%h exp wr=1 addr=300",
                 k, mem_read[k], mem_write[k], mem_addr[k]);
      end
    end
    mem_resp = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      i_read[k] = 1'b1; i_addr[k] = 32'h400;
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (mem_read[k] !== 1'b1) begin
        bad++; $display("FAIL midrst_grant k=%0d got mem_read=%b exp 1", k, mem_read[k]);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({mem_read[k], mem_write[k]} !== 2'b00) begin
        bad++; $display("FAIL midrst_drop k=%0d got rd=%b wr=%b exp 0 0", k, mem_read[k], mem_write[k]);
      end
    end
    for (int k = 0; k < 2; k++) i_read[k] = 1'b0;
    mem_resp = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({i_resp[k], d_resp[k]} !== 2'b00) begin
        bad++; $display("FAIL midrst_noresp k=%0d got ir=%b dr=%b exp 0 0", k, i_resp[k], d_resp[k]);
      end
    end
    tick();
    mem_resp = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_read[k] = 1'b1; i_addr[k] = 32'h100; d_read[k] = 1'b1; d_addr[k] = 32'h200;
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({mem_read[k], mem_addr[k]} !== {1'b1, 32'h200}) begin
        bad++;
        $display("FAIL midrst_tie_d k=%0d got rd=%b addr=%h exp rd=1 addr=200", k, mem_read[k], mem_addr[k]);
      end
    end
    clear_inputs();
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
  endtask

  task automatic test_rw_violation();
    logic [LW-1:0] pat;
    do_reset();
    pat = rand_line();
    for (int k = 0; k < 2; k++) begin
      i_read[k] = 1'b1; i_write[k] = 1'b1; i_addr[k] = 32'h500; i_wdata[k] = pat;
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({mem_read[k], mem_write[k], mem_addr[k], mem_wdata[k]} !== {2'b11, 32'h500, pat}) begin
        bad++;
        $display("FAIL rw_forward k=%0d got rd=%b wr=%b addr=%h exp rd=1 wr=1 addr=500",
                 k, mem_read[k], mem_write[k], mem_addr[k]);
      end
    end
    mem_resp = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic test_random();
    bit act_i[2], act_d[2], got_i[2], got_d[2];
    bit exp_ir, exp_dr;
    logic [LW+33:0] exp_b;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      act_i[k] = 1'b0; act_d[k] = 1'b0; got_i[k] = 1'b0; got_d[k] = 1'b0;
    end
    for (int c = 0; c < 500; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (got_i[k]) begin i_read[k] = 1'b0; i_write[k] = 1'b0; act_i[k] = 1'b0; end
        if (got_d[k]) begin d_read[k] = 1'b0; d_write[k] = 1'b0; act_d[k] = 1'b0; end
        if (!act_i[k] && $urandom_range(0, 2) == 0) begin
          i_read[k] = $urandom_range(0, 1) == 1; i_write[k] = !i_read[k];
          i_addr[k] = $urandom; i_wdata[k] = rand_line(); act_i[k] = 1'b1;
        end
        if (!act_d[k] && $urandom_range(0, 2) == 0) begin
          d_read[k] = $urandom_range(0, 1) == 1; d_write[k] = !d_read[k];
          d_addr[k] = $urandom; d_wdata[k] = rand_line(); act_d[k] = 1'b1;
        end
      end
      mem_resp  = $urandom_range(0, 2) == 0;
      mem_rdata = rand_line();
      #1;
      for (int k = 0; k < 2; k++) begin
        exp_b  = exp_mem(k);
        exp_ir = (m_owner[k] == SI) && mem_resp;
        exp_dr = (m_owner[k] == SD) && mem_resp;
        total++;
        if ({mem_read[k], mem_write[k], mem_addr[k], mem_wdata[k]} !== exp_b) begin
          bad++;
          $display("FAIL rand_mem c=%0d k=%0d got rd=%b wr=%b addr=%h exp rd=%b wr=%b addr=%h",
                   c, k, mem_read[k], mem_write[k], mem_addr[k], exp_b[LW+33], exp_b[LW+32], exp_b[LW+31:LW]);
        end
        total++;
        if ({i_resp[k], d_resp[k], i_rdata[k], d_rdata[k]} !== {exp_ir, exp_dr, mem_rdata, mem_rdata}) begin
          bad++;
          $display("FAIL rand_resp c=%0d k=%0d got ir=%b dr=%b exp ir=%b dr=%b", c, k, i_resp[k], d_resp[k], exp_ir, exp_dr);
        end
        got_i[k] = exp_ir;
        got_d[k] = exp_dr;
      end
      tick();
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = NONE; m_last[k] = SI;
    end
    rst = 1'b1;
    mem_rdata = '0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_tie();
    test_contention();
    test_idle_ties();
    test_stray();
    test_reset_mid_grant();
    test_rw_violation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
